// File: rtl/edge_pkg.sv
// Shared types and helpers for the edge-detect frame sequencer.
// Holds the sequencer state encoding, the kernel/pixel/result widths, and
// the small lookup functions that split a linear kernel index k (0..8)
// into its row and column within the 3x3 window.
package edge_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    FETCH       = 3'd1,
    LAUNCH      = 3'd2,
    WAIT_RESULT = 3'd3,
    WRITE       = 3'd4,
    DONE        = 3'd5
  } seq_state_t;

  localparam int KSIZE  = 3;
  localparam int PIX_W  = 4;
  localparam int EDGE_W = 2;

  // Last kernel index that issues a read, and last FETCH cycle index.
  localparam logic [3:0] K_LAST_RD = 4'd8;
  localparam logic [3:0] K_LAST    = 4'd9;

  // Row of kernel element k (k / 3).
  function automatic logic [1:0] k_row(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: k_row = 2'd0;
      4'd3, 4'd4, 4'd5: k_row = 2'd1;
      4'd6, 4'd7, 4'd8: k_row = 2'd2;
      default:          k_row = 2'd0;
    endcase
  endfunction

  // Column of kernel element k (k % 3).
  function automatic logic [1:0] k_col(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: k_col = 2'd0;
      4'd1, 4'd4, 4'd7: k_col = 2'd1;
      4'd2, 4'd5, 4'd8: k_col = 2'd2;
      default:          k_col = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/edge_win_addr_gen.sv
// Window / kernel address generator for the edge frame sequencer.
// Keeps the window position (r, c) and the FETCH cycle index k, and produces
// the registered pixel read strobe/address, the registered result address
// and a combinational last-window flag.
// Ports:
//   frame_start - IDLE is accepting start: clear r/c/k, first read next cycle
//   win_done    - WRITE cycle: advance to next window, restart k
//   fetch_step  - FETCH cycle: step k
//   out_load    - next cycle is WRITE: latch r*(IMG_W-2)+c into out_addr
//   pix_rd_en / pix_addr - pixel RAM read port (registered)
//   out_addr    - result RAM address (registered)
//   k_idx       - current FETCH cycle index 0..9
//   last_win    - current window is the final one of the frame
module edge_win_addr_gen
  import edge_pkg::*;
#(
  parameter int IMG_W      = 16,
  parameter int IMG_H      = 16,
  parameter int PIX_ADDR_W = 8,
  parameter int OUT_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  frame_start,
  input  logic                  win_done,
  input  logic                  fetch_step,
  input  logic                  out_load,
  output logic                  pix_rd_en,
  output logic [PIX_ADDR_W-1:0] pix_addr,
  output logic [OUT_ADDR_W-1:0] out_addr,
  output logic [3:0]            k_idx,
  output logic                  last_win
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic [RW-1:0]         r_q, r_d;
  logic [CW-1:0]         c_q, c_d;
  logic [3:0]            k_q, k_d;
  logic                  pix_rd_en_q, pix_rd_en_d;
  logic [PIX_ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [OUT_ADDR_W-1:0] out_addr_q, out_addr_d;

  assign last_win  = (r_q == RW'(IMG_H - 3)) && (c_q == CW'(IMG_W - 3));
  assign pix_rd_en = pix_rd_en_q;
  assign pix_addr  = pix_addr_q;
  assign out_addr  = out_addr_q;
  assign k_idx     = k_q;

  // Next-state for counters and addresses. The read address is computed from
  // the next-cycle r/c/k so that the registered strobe lines up with FETCH k.
  always_comb begin
    r_d        = r_q;
    c_d        = c_q;
    k_d        = k_q;
    pix_addr_d = pix_addr_q;
    out_addr_d = out_addr_q;

    if (frame_start) begin
      r_d = RW'(1'b0);
      c_d = CW'(1'b0);
      k_d = 4'd0;
    end else if (win_done) begin
      k_d = 4'd0;
      if (!last_win) begin
        if (c_q == CW'(IMG_W - 3)) begin
          c_d = CW'(1'b0);
          r_d = r_q + RW'(1'b1);
        end else begin
          c_d = c_q + CW'(1'b1);
        end
      end else begin
        c_d = c_q;
      end
    end else if (fetch_step && (k_q != K_LAST)) begin
      k_d = k_q + 4'd1;
    end else begin
      k_d = k_q;
    end

    // A read is issued in every FETCH cycle whose index is 0..8.
    pix_rd_en_d = (frame_start || (win_done && !last_win) ||
                   (fetch_step && (k_q != K_LAST))) && (k_d <= K_LAST_RD);

    if (pix_rd_en_d) begin
      pix_addr_d = PIX_ADDR_W'((32'(r_d) + 32'(k_row(k_d))) * 32'(IMG_W) +
                               32'(c_d) + 32'(k_col(k_d)));
    end else begin
      pix_addr_d = pix_addr_q;
    end

    if (out_load) begin
      out_addr_d = OUT_ADDR_W'(32'(r_q) * 32'(IMG_W - 2) + 32'(c_q));
    end else begin
      out_addr_d = out_addr_q;
    end
  end

  // Counter and address registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_q         <= RW'(1'b0);
      c_q         <= CW'(1'b0);
      k_q         <= 4'd0;
      pix_rd_en_q <= 1'b0;
      pix_addr_q  <= PIX_ADDR_W'(1'b0);
      out_addr_q  <= OUT_ADDR_W'(1'b0);
    end else begin
      r_q         <= r_d;
      c_q         <= c_d;
      k_q         <= k_d;
      pix_rd_en_q <= pix_rd_en_d;
      pix_addr_q  <= pix_addr_d;
      out_addr_q  <= out_addr_d;
    end
  end

endmodule

// File: rtl/edge_frame_sequencer.sv
// Frame-level controller for the edge-detect datapath.
// Raster-scans every interior 3x3 window of an IMG_W x IMG_H image held in a
// 1-cycle-latency pixel RAM, hands each window to the edge detector, waits for
// its result (bounded by TIMEOUT) and writes it to the result RAM.
// Ports:
//   start              - begin a frame (only honoured in IDLE)
//   busy / done        - activity flag / one-cycle frame-complete pulse
//   protoErr           - sticky timeout / unexpected-result flag, cleared on start
//   pixRdEn/pixAddr/pixRdData - pixel RAM read port
//   winData/winValid   - window [row][col] and launch pulse to the detector
//   edgeVal/edgeValValid - detector result
//   outWrEn/outAddr/outData - result RAM write port
module edge_frame_sequencer
  import edge_pkg::*;
#(
  parameter int IMG_W      = 16,
  parameter int IMG_H      = 16,
  parameter int PIX_ADDR_W = 8,
  parameter int OUT_ADDR_W = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                                      clk,
  input  logic                                      nreset,
  input  logic                                      start,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      protoErr,
  output logic                                      pixRdEn,
  output logic [PIX_ADDR_W-1:0]                     pixAddr,
  input  logic [PIX_W-1:0]                          pixRdData,
  output logic [KSIZE-1:0][KSIZE-1:0][PIX_W-1:0]    winData,
  output logic                                      winValid,
  input  logic [EDGE_W-1:0]                         edgeVal,
  input  logic                                      edgeValValid,
  output logic                                      outWrEn,
  output logic [OUT_ADDR_W-1:0]                     outAddr,
  output logic [EDGE_W-1:0]                         outData
);

  localparam int TW = $clog2(TIMEOUT + 1);

  // Parameter sanity, evaluated at elaboration.
  if (IMG_W < 3) begin : g_chk_w
    $error("IMG_W must be at least 3");
  end
  if (IMG_H < 3) begin : g_chk_h
    $error("IMG_H must be at least 3");
  end
  if (PIX_ADDR_W < $clog2(IMG_W * IMG_H)) begin : g_chk_pa
    $error("PIX_ADDR_W too narrow for IMG_W*IMG_H");
  end
  if (OUT_ADDR_W < $clog2((IMG_W - 2) * (IMG_H - 2))) begin : g_chk_oa
    $error("OUT_ADDR_W too narrow for the result image");
  end
  if (TIMEOUT < 1) begin : g_chk_to
    $error("TIMEOUT must be at least 1");
  end

  seq_state_t state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic err_q, err_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic win_valid_q, win_valid_d;
  logic out_wr_en_q, out_wr_en_d;
  logic [EDGE_W-1:0] out_data_q, out_data_d;
  logic [KSIZE-1:0][KSIZE-1:0][PIX_W-1:0] win_q, win_d;

  logic frame_start, win_done, fetch_step, out_load;
  logic [3:0] k_idx;
  logic last_win;

  edge_win_addr_gen #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .PIX_ADDR_W(PIX_ADDR_W),
    .OUT_ADDR_W(OUT_ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .nreset     (nreset),
    .frame_start(frame_start),
    .win_done   (win_done),
    .fetch_step (fetch_step),
    .out_load   (out_load),
    .pix_rd_en  (pixRdEn),
    .pix_addr   (pixAddr),
    .out_addr   (outAddr),
    .k_idx      (k_idx),
    .last_win   (last_win)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign protoErr = err_q;
  assign winValid = win_valid_q;
  assign winData  = win_q;
  assign outWrEn  = out_wr_en_q;
  assign outData  = out_data_q;

  // Sequencer next-state, window capture, timeout and error logic.
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    err_d       = err_q;
    out_data_d  = out_data_q;
    win_d       = win_q;
    frame_start = 1'b0;
    win_done    = 1'b0;
    fetch_step  = 1'b0;
    out_load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FETCH;
          frame_start = 1'b1;
          err_d       = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        fetch_step = 1'b1;
        // Data for read k-1 is on pixRdData during FETCH cycle k.
        if (k_idx != 4'd0) begin
          win_d[k_row(k_idx - 4'd1)][k_col(k_idx - 4'd1)] = pixRdData;
        end else begin
          win_d = win_q;
        end
        if (k_idx == K_LAST) begin
          state_d = LAUNCH;
        end else begin
          state_d = FETCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT_RESULT;
        tcnt_d  = TW'(1'b0);
      end
      WAIT_RESULT: begin
        // A result arriving on the expiry cycle still counts as on time.
        if (edgeValValid) begin
          out_data_d = edgeVal;
          out_load   = 1'b1;
          state_d    = WRITE;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          out_data_d = 2'd0;
          err_d      = 1'b1;
          out_load   = 1'b1;
          state_d    = WRITE;
        end else begin
          tcnt_d = tcnt_q + TW'(1'b1);
        end
      end
      WRITE: begin
        win_done = 1'b1;
        state_d  = last_win ? DONE : FETCH;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A result strobe outside WAIT_RESULT is a protocol error; it also
    // overrides the clear on an accepted start.
    if (edgeValValid && (state_q != WAIT_RESULT)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end

    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    win_valid_d = (state_d == LAUNCH);
    out_wr_en_d = (state_d == WRITE);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      tcnt_q      <= TW'(1'b0);
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      win_valid_q <= 1'b0;
      out_wr_en_q <= 1'b0;
      out_data_q  <= 2'd0;
      win_q       <= '0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      win_valid_q <= win_valid_d;
      out_wr_en_q <= out_wr_en_d;
      out_data_q  <= out_data_d;
      win_q       <= win_d;
    end
  end

endmodule
